fifo_mem_ctrl: RTL and testbench
================================

// Module: fifo_mem_ctrl
// PURPOSE
//  Push/pop FIFO controller in front of the dual-port memory (AW=3, DW=4).
//  Holds the write/read pointers, occupancy count and status flags.
//  Drives memory port A as the write port and port B as the read port.
//  Upstream logic sees a plain FIFO interface: push/data_in in, pop/data_out/valid_out out.
// PARAMETERS
//  AW     3  memory address width; DEPTH = 2**AW entries
//  DW     4  data width
//  AF_TH  6  almost_full asserted when count >= AF_TH
//  AE_TH  2  almost_empty asserted when count <= AE_TH
// PORTS
//  clk           in   1     global clock, all state on rising edge
//  reset         in   1     synchronous, active-high
//  push          in   1     write request
//  data_in       in   DW    write data
//  pop           in   1     read request
//  data_out      out  DW    read data = DataOutB, meaningful only while valid_out=1
//  valid_out     out  1     data_out holds a popped word
//  full          out  1     count == DEPTH
//  empty         out  1     count == 0
//  almost_full   out  1     count >= AF_TH
//  almost_empty  out  1     count <= AE_TH
//  count         out  AW+1  occupancy, 0..DEPTH
//  overflow      out  1     1-cycle pulse: push rejected
//  underflow     out  1     1-cycle pulse: pop rejected
//  AddrA         out  AW    memory write address = wr_ptr[AW-1:0]
//  rwA           out  1     memory port A mode, 0=write, 1=read/idle
//  DataInA       out  DW    memory write data = data_in
//  AddrB         out  AW    memory read address = rd_ptr[AW-1:0]
//  rwB           out  1     tied 1; port B is read-only
//  DataOutB      in   DW    memory read data, registered by memory 1 cycle after AddrB
// BEHAVIOUR
//  - Reset values: wr_ptr=0, rd_ptr=0, count=0, valid_out=0, overflow=0, underflow=0.
//    Flags follow count: empty=1, almost_empty=1, full=0, almost_full=0. rwA=1.
//  - Reset dominates push/pop in the same cycle. Memory contents are not cleared.
//  - Pointers are AW+1 bits; the MSB is the wrap bit. Each increments mod 2*DEPTH.
//  - Acceptance:
//    - push_ok = push & ~full
//    - pop_ok  = pop & ~empty
//    Flags are evaluated on the current registered count.
//  - rwA = ~push_ok, combinational. The memory writes data_in at AddrA on the same edge.
//  - Edge with push_ok: wr_ptr+1. Edge with pop_ok: rd_ptr+1.
//  - count update: push_ok & ~pop_ok -> count+1; pop_ok & ~push_ok -> count-1; otherwise unchanged.
//  - Read latency is 1 cycle. pop_ok at edge k -> valid_out=1 for the cycle after k, with data_out = word at old rd_ptr.
//  - Back-to-back pops give one word per cycle.
//  - Full + push + pop: pop accepted, push rejected, overflow=1, count becomes DEPTH-1.
//    Write-into-full is never allowed; AddrA==AddrB when full.
//  - Empty + push + pop: push accepted, pop rejected, underflow=1, count becomes 1.
//    No fall-through path.
//  - Neither full nor empty + push + pop: both accepted, count unchanged.
//  - overflow/underflow are registered and last 1 cycle. They are not sticky and leave state unchanged.
//  - Wrap-around: after DEPTH pushes, AddrA returns to 0. full uses count, not pointer compare.
//  - Reset during a pending read: valid_out is forced to 0 next cycle and the word is dropped.
// STRUCTURE
//  - Shared package fifo_pkg holds localparams DEPTH=2**AW and CNT_W=AW+1, plus the rwA/rwB encoding constants (RW_WRITE=0, RW_READ=1).
//  - One sub-module, fifo_ptr: an AW+1-bit pointer register with synchronous reset and increment enable.
//    Instantiated twice, for wr_ptr and rd_ptr.
//  - Count, flags, error pulses and valid_out live in the top level.
// TESTING  (AW=3, DW=4, DEPTH=8, AF_TH=6, AE_TH=2)
//  - Reset: hold reset 2 cycles with push=1 -> count=0, empty=1, almost_empty=1, valid_out=0, rwA=1.
//  - Fill: 8 pushes of 4'h1..4'h8 -> AddrA steps 0..7.
//    almost_empty drops at count=3, almost_full rises at count=6, full=1 at count=8.
//    A 9th push -> overflow pulse, count stays 8.
//  - Drain: 8 pops -> valid_out each following cycle, data_out 1..8 in order, empty=1.
//    A 9th pop -> underflow pulse, valid_out=0.
//  - Wrap: push 5 (4'hA..4'hE), pop 5, push 5 more -> AddrA wraps 7->0.
//    Popped order is preserved across the wrap.
//  - Simultaneous: at count=8, push+pop -> overflow=1, count=7, data_out=oldest word.
//    At count=0, push+pop -> underflow=1, count=1. At count=4, push+pop -> count stays 4.
//  - Reset mid-stream: pop at count=3, then reset next cycle -> valid_out=0, count=0, AddrA=AddrB=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller in front of the dual-port memory.
// Holds the memory geometry (address/data widths, depth, counter width) and
// the port-mode encoding used on rwA/rwB.
package fifo_pkg;
  localparam int AW    = 3;
  localparam int DW    = 4;
  localparam int DEPTH = 2 ** AW;
  localparam int CNT_W = AW + 1;

  // Memory port mode encoding.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/fifo_mem_ctrl_if.sv
// Bundle of every non-clock signal around the FIFO controller.
// Upstream side: push/data_in/pop in, data_out/valid_out/status out.
// Memory side:   AddrA/rwA/DataInA (write port), AddrB/rwB (read port) out,
//                DataOutB (registered read data) in.
// Modports:
//   slave  - the controller itself
//   master - the environment (upstream logic plus the memory)
//
// Handshake: a push is accepted on a rising edge when push=1 and full=0; a
// pop is accepted when pop=1 and empty=0. A rejected request raises
// overflow/underflow for exactly one cycle. An accepted pop produces
// valid_out=1 with data_out the popped word during the following cycle.
interface fifo_mem_ctrl_if;
  import fifo_pkg::*;

  logic              push;
  logic [DW-1:0]     data_in;
  logic              pop;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic [AW-1:0]     AddrA;
  logic              rwA;
  logic [DW-1:0]     DataInA;
  logic [AW-1:0]     AddrB;
  logic              rwB;
  logic [DW-1:0]     DataOutB;

  modport slave (
    input  push, data_in, pop, DataOutB,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow, AddrA, rwA, DataInA, AddrB, rwB
  );

  modport master (
    output push, data_in, pop, DataOutB,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow, AddrA, rwA, DataInA, AddrB, rwB
  );
endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: W bits, synchronous active-high reset to 0,
// increments by one (mod 2**W) on each rising edge where inc=1.
// Ports: clk, reset, inc (increment enable), ptr (current value).
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end
endmodule

// File: rtl/fifo_mem_ctrl.sv
// Push/pop FIFO controller driving a dual-port memory with registered reads.
// Port A is the write port, port B is the read-only port. Tracks write/read
// pointers, occupancy and status flags; rejected requests give one-cycle
// overflow/underflow pulses.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; dominates push/pop
//   bus    - fifo_mem_ctrl_if.slave (upstream FIFO signals + memory ports)
// Parameters:
//   AF_TH  - almost_full when count >= AF_TH
//   AE_TH  - almost_empty when count <= AE_TH
module fifo_mem_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_TH = 6,
  parameter int AE_TH = 2
) (
  input  logic            clk,
  input  logic            reset,
  fifo_mem_ctrl_if.slave  bus
);
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;
  logic             valid_q;
  logic             overflow_q;
  logic             underflow_q;

  // Flags come from the registered count only, never from pointer compares.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Reset masks acceptance so the memory is never written while in reset.
  assign push_ok = bus.push & ~full  & ~reset;
  assign pop_ok  = bus.pop  & ~empty & ~reset;

  fifo_ptr #(.W(CNT_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(CNT_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok && !pop_ok) begin
        count <= count + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_W'(1);
      end
      // The memory registers the word at AddrB on this same edge, so
      // valid_out lines up with DataOutB one cycle after the pop.
      valid_q     <= pop_ok;
      overflow_q  <= bus.push & ~push_ok;
      underflow_q <= bus.pop  & ~pop_ok;
    end
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CNT_W'(AF_TH));
  assign bus.almost_empty = (count <= CNT_W'(AE_TH));
  assign bus.count        = count;
  assign bus.valid_out    = valid_q;
  assign bus.data_out     = bus.DataOutB;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  assign bus.AddrA   = wr_ptr[AW-1:0];
  assign bus.rwA     = push_ok ? RW_WRITE : RW_READ;
  assign bus.DataInA = bus.data_in;
  assign bus.AddrB   = rd_ptr[AW-1:0];
  assign bus.rwB     = RW_READ;
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl: directed phases followed by random push/pop
// traffic, all compared against a queue-based FIFO model. Includes a small
// behavioural dual-port memory with a registered read port.
module tb_fifo_mem_ctrl;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fifo_mem_ctrl_if bus ();

  fifo_mem_ctrl #(.AF_TH(6), .AE_TH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / memory model
  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.rwA == RW_WRITE) mem[bus.AddrA] <= bus.DataInA;
    bus.DataOutB <= mem[bus.AddrB];
  end

  // Reference model
  logic [DW-1:0] exp_q[$];
  int            wp_cnt = 0;   // accepted pushes since reset
  int            rp_cnt = 0;   // accepted pops since reset
  bit            exp_valid = 0;
  logic [DW-1:0] exp_data = '0;
  bit            exp_over = 0;
  bit            exp_under = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // advance the model at the edge and check registered outputs.
  task automatic step(input bit rst, input bit ph, input logic [DW-1:0] d, input bit pp);
    bit m_full, m_empty, pok, rok;
    @(negedge clk);
    reset       = rst;
    bus.push    = ph;
    bus.data_in = d;
    bus.pop     = pp;
    m_full  = (exp_q.size() == DEPTH);
    m_empty = (exp_q.size() == 0);
    pok = ph && !m_full && !rst;
    rok = pp && !m_empty && !rst;
    #1;
    chk("rwA", bus.rwA, pok ? 0 : 1);
    chk("DataInA", bus.DataInA, d);
    if (pok) chk("AddrA_wr", bus.AddrA, wp_cnt % DEPTH);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      wp_cnt = 0; rp_cnt = 0;
      exp_valid = 0; exp_over = 0; exp_under = 0;
    end else begin
      exp_valid = rok;
      if (rok) begin
        exp_data = exp_q.pop_front();
        rp_cnt++;
      end
      if (pok) begin
        exp_q.push_back(d);
        wp_cnt++;
      end
      exp_over  = ph && !pok;
      exp_under = pp && !rok;
    end
    #1;
    chk("count", bus.count, exp_q.size());
    chk("empty", bus.empty, exp_q.size() == 0);
    chk("full", bus.full, exp_q.size() == DEPTH);
    chk("almost_full", bus.almost_full, exp_q.size() >= 6);
    chk("almost_empty", bus.almost_empty, exp_q.size() <= 2);
    chk("valid_out", bus.valid_out, exp_valid);
    if (exp_valid) chk("data_out", bus.data_out, exp_data);
    chk("overflow", bus.overflow, exp_over);
    chk("underflow", bus.underflow, exp_under);
    chk("AddrA", bus.AddrA, wp_cnt % DEPTH);
    chk("AddrB", bus.AddrB, rp_cnt % DEPTH);
    chk("rwB", bus.rwB, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;

    // Reset held two cycles with push asserted
    step(1, 1, 4'h5, 0);
    step(1, 1, 4'h5, 0);

    // Fill 1..8, then a rejected ninth push
    for (int i = 1; i <= 8; i++) step(0, 1, 4'(i), 0);
    step(0, 1, 4'hF, 0);

    // Drain in order, then a rejected ninth pop
    for (int i = 0; i < 8; i++) step(0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 0);

    // Wrap-around: A..E, pop 5, push 5 more (AddrA 5,6,7,0,1)
    for (int i = 0; i < 5; i++) step(0, 1, 4'(4'hA + i), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 4'($urandom_range(0, 15)), 0);
    while (exp_q.size() > 0) step(0, 0, 4'h0, 1);

    // Simultaneous push+pop at full, empty and mid occupancy
    for (int i = 0; i < 8; i++) step(0, 1, 4'($urandom_range(0, 15)), 0);
    step(0, 1, 4'h3, 1);
    while (exp_q.size() > 0) step(0, 0, 4'h0, 1);
    step(0, 1, 4'h9, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 4'($urandom_range(0, 15)), 0);
    step(0, 1, 4'h6, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Reset right after a pop at count=3
    while (exp_q.size() > 0) step(0, 0, 4'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 4'($urandom_range(0, 15)), 0);
    step(0, 0, 4'h0, 1);
    step(1, 0, 4'h0, 0);
    step(0, 0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
